// File: rtl/error_injection_ctrl.sv
// error_injection_ctrl: sequences fault-injection campaigns on an encoded word stream.
// Passes a programmed number of clean words, then corrupts the next valid word at an
// LFSR-chosen bit position, repeating until the programmed injection count is reached.
// Optional feature macro: INJ_DOUBLE_ERROR_EN (enables 2-bit masks via double_mode_i).
module error_injection_ctrl #(
   parameter int unsigned WIDTH = 38,
   parameter logic [15:0] SEED  = 16'h0025
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [15:0]      num_injections_i,
   input  logic [7:0]       interval_i,
   input  logic             double_mode_i,
   input  logic             data_valid_i,
   input  logic [WIDTH-1:0] data_in_i,
   output logic [WIDTH-1:0] data_out_o,
   output logic             data_out_valid_o,
   output logic [WIDTH-1:0] error_mask_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [15:0]      inject_count_o
);

   typedef enum logic [1:0] {StIdle, StGap, StInject, StDone} state_e;

   localparam logic [6:0] WidthW = 7'(WIDTH);

   state_e           state_q, state_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic [7:0]       interval_q, interval_d;
   logic [15:0]      num_inj_q, num_inj_d;
   logic [15:0]      inj_cnt_q, inj_cnt_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic             dbl_q, dbl_d;
   logic             inject;
   logic [6:0]       p0;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] data_out_q;
   logic [WIDTH-1:0] mask_q;
   logic             valid_q;

   // Bit positions derived from the current LFSR value, reduced modulo WIDTH.
   always_comb begin
      p0 = {1'b0, lfsr_q[5:0]};
      if (p0 >= WidthW) p0 = p0 - WidthW;
   end

`ifdef INJ_DOUBLE_ERROR_EN
   logic [6:0] p1;

   // Second position; collisions with p0 are bumped to the next bit, wrapping at WIDTH.
   always_comb begin
      p1 = {1'b0, lfsr_q[11:6]};
      if (p1 >= WidthW) p1 = p1 - WidthW;
      if (p1 == p0) p1 = (p0 + 7'd1 == WidthW) ? 7'd0 : p0 + 7'd1;
   end

   // Mask is non-zero only for the word being injected.
   always_comb begin
      mask = '0;
      if (inject) begin
         mask = WIDTH'(1) << p0;
         if (dbl_q) mask = mask | (WIDTH'(1) << p1);
      end
   end
`else
   logic unused_double_mode;
   assign unused_double_mode = double_mode_i;

   // Mask is non-zero only for the word being injected.
   always_comb begin
      mask = '0;
      if (inject) mask = WIDTH'(1) << p0;
   end
`endif

   // Campaign sequencing; abort overrides every transition but not a same-cycle injection.
   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      interval_d = interval_q;
      num_inj_d  = num_inj_q;
      inj_cnt_d  = inj_cnt_q;
      lfsr_d     = lfsr_q;
      dbl_d      = dbl_q;
      inject     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i && !abort_i) begin
               inj_cnt_d  = '0;
               gap_cnt_d  = '0;
               num_inj_d  = num_injections_i;
               interval_d = interval_i;
`ifdef INJ_DOUBLE_ERROR_EN
               dbl_d      = double_mode_i;
`endif
               if (num_injections_i == 16'd0) state_d = StDone;
               else if (interval_i == 8'd0)   state_d = StInject;
               else                           state_d = StGap;
            end
         end
         StGap: begin
            if (data_valid_i) begin
               gap_cnt_d = gap_cnt_q + 8'd1;
               if (gap_cnt_d == interval_q) state_d = StInject;
            end
         end
         StInject: begin
            if (data_valid_i) begin
               inject    = 1'b1;
               inj_cnt_d = (inj_cnt_q == 16'hFFFF) ? inj_cnt_q : inj_cnt_q + 16'd1;
               lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
               if (inj_cnt_d == num_inj_q) begin
                  state_d = StDone;
               end else if (interval_q == 8'd0) begin
                  state_d = StInject;
               end else begin
                  state_d   = StGap;
                  gap_cnt_d = '0;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort_i) state_d = StIdle;
   end

   // Control state registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         gap_cnt_q  <= '0;
         interval_q <= '0;
         num_inj_q  <= '0;
         inj_cnt_q  <= '0;
         lfsr_q     <= SEED;
         dbl_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         interval_q <= interval_d;
         num_inj_q  <= num_inj_d;
         inj_cnt_q  <= inj_cnt_d;
         lfsr_q     <= lfsr_d;
         dbl_q      <= dbl_d;
      end
   end

   // Registered datapath; words always flow through, even when idle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_out_q <= '0;
         mask_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         data_out_q <= data_in_i ^ mask;
         mask_q     <= mask;
         valid_q    <= data_valid_i;
      end
   end

   assign data_out_o       = data_out_q;
   assign error_mask_o     = mask_q;
   assign data_out_valid_o = valid_q;
   assign busy_o           = (state_q == StGap) || (state_q == StInject);
   assign done_o           = (state_q == StDone);
   assign inject_count_o   = inj_cnt_q;

endmodule
